systolic_stw_bist_ctrl: RTL and testbench

//  Multi-pattern self-test sequencer for the ROWS x COLS STW-enabled systolic MAC array.

---
 rtl/systolic_stw_bist_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_systolic_stw_bist_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_stw_bist_ctrl.sv
// systolic_stw_bist_ctrl: multi-pattern STW self-test sequencer for the systolic MAC array.
// Loads patterns into a buffer, broadcasts each to the array and builds a sticky per-PE fault map.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   pat_wr_*            pattern buffer write port {op1,op2,add_op,expected}, honoured in IDLE only
//   num_pat             patterns to run this session (clamped to NUM_PATTERNS)
//   bist_start          session start, accepted in IDLE only
//   bist_busy/done      session in progress / 1-cycle end pulse
//   bist_pass           last session clean (no faults, no timeout)
//   timeout_err         last session aborted in WAIT
//   fault_map/count     sticky per-PE fail bits (r*COLS+c) and their popcount
//   STW_*               broadcast test port of the array
module systolic_stw_bist_ctrl #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int WORD_SIZE    = 16,
    parameter int NUM_PATTERNS = 8,
    parameter int TIMEOUT      = 64,
    localparam int PAW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int NPE = ROWS * COLS,
    localparam int CW  = $clog2(NPE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pat_wr_en,
    input  logic [PAW-1:0]         pat_wr_addr,
    input  logic [4*WORD_SIZE-1:0] pat_wr_data,
    input  logic [PAW:0]           num_pat,
    input  logic                   bist_start,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   bist_pass,
    output logic                   timeout_err,
    output logic [NPE-1:0]         fault_map,
    output logic [CW-1:0]          fault_count,
    output logic [WORD_SIZE-1:0]   STW_mult_op1,
    output logic [WORD_SIZE-1:0]   STW_mult_op2,
    output logic [WORD_SIZE-1:0]   STW_add_op,
    output logic [WORD_SIZE-1:0]   STW_expected,
    output logic                   STW_test_load_en,
    output logic                   STW_start,
    input  logic                   STW_complete_in,
    input  logic [NPE-1:0]         STW_result_in
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit ADDR_FULL = (NUM_PATTERNS == (1 << PAW));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state, state_d;
    logic [PAW-1:0]         idx, idx_d;
    logic [PAW:0]           npat, npat_d;
    logic [TW-1:0]          wait_cnt, wait_d;
    logic [NPE-1:0]         fmap_d;
    logic                   terr_d;
    logic                   load_ops;
    logic                   start_ok;
    logic                   addr_ok;
    logic [PAW:0]           npat_clamp;
    logic [4*WORD_SIZE-1:0] ops_q;
    logic [4*WORD_SIZE-1:0] mem [NUM_PATTERNS];

    function automatic logic [CW-1:0] popcnt(input logic [NPE-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NPE; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // With a power-of-two depth every address is in range.
    generate
        if (ADDR_FULL) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = ({1'b0, pat_wr_addr} < (PAW+1)'(NUM_PATTERNS));
        end
    endgenerate

    assign npat_clamp = (num_pat > (PAW+1)'(NUM_PATTERNS)) ?
                        (PAW+1)'(NUM_PATTERNS) : num_pat;
    assign start_ok   = (state == S_IDLE) && bist_start;

    // Buffer has no reset: contents survive a session abort.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && pat_wr_en && addr_ok) begin
            mem[pat_wr_addr] <= pat_wr_data;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        npat_d   = npat;
        wait_d   = wait_cnt;
        fmap_d   = fault_map;
        terr_d   = timeout_err;
        load_ops = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bist_start) begin
                    fmap_d = '0;
                    terr_d = 1'b0;
                    idx_d  = '0;
                    npat_d = npat_clamp;
                    if (num_pat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_LOAD;
                        load_ops = 1'b1;
                    end
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                // Complete on the first WAIT cycle is left over from the
                // previous pattern and must be ignored.
                if (wait_cnt != '0 && STW_complete_in) begin
                    state_d = S_CAPTURE;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_cnt + TW'(1);
                end
            end
            S_CAPTURE: begin
                fmap_d = fault_map | STW_result_in;
                if ({1'b0, idx} == npat - (PAW+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx + PAW'(1);
                    state_d  = S_LOAD;
                    load_ops = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            npat        <= '0;
            wait_cnt    <= '0;
            fault_map   <= '0;
            timeout_err <= 1'b0;
            bist_pass   <= 1'b0;
            fault_count <= '0;
            ops_q       <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            npat        <= npat_d;
            wait_cnt    <= wait_d;
            fault_map   <= fmap_d;
            timeout_err <= terr_d;
            if (load_ops) begin
                ops_q <= mem[idx_d];
            end
            if (start_ok) begin
                bist_pass   <= 1'b0;
                fault_count <= '0;
            end
            // Summary is registered on DONE entry so it is valid with bist_done.
            if (state_d == S_DONE) begin
                bist_pass   <= ~terr_d & ~|fmap_d;
                fault_count <= popcnt(fmap_d);
            end
        end
    end

    assign bist_busy        = (state != S_IDLE);
    assign bist_done        = (state == S_DONE);
    assign STW_test_load_en = (state == S_LOAD);
    assign STW_start        = (state == S_START);

    assign STW_mult_op1 = ops_q[4*WORD_SIZE-1 -: WORD_SIZE];
    assign STW_mult_op2 = ops_q[3*WORD_SIZE-1 -: WORD_SIZE];
    assign STW_add_op   = ops_q[2*WORD_SIZE-1 -: WORD_SIZE];
    assign STW_expected = ops_q[WORD_SIZE-1:0];

endmodule

// File: tb/tb_systolic_stw_bist_ctrl.sv
// tb_systolic_stw_bist_ctrl: scoreboard bench for the STW BIST sequencer.
// A behavioural array model answers STW_start; session results are queued and checked on bist_done.
module tb_systolic_stw_bist_ctrl;

    localparam int NP  = 8;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        pat_wr_en;
    logic [2:0]  pat_wr_addr;
    logic [63:0] pat_wr_data;
    logic [3:0]  num_pat;
    logic        bist_start;
    logic        bist_busy, bist_done, bist_pass, timeout_err;
    logic [15:0] fault_map;
    logic [4:0]  fault_count;
    logic [15:0] op1, op2, addop, expv;
    logic        load_en, stw_start;
    logic        complete;
    logic [15:0] result;

    typedef struct {
        logic        pass;
        logic        terr;
        logic [15:0] fmap;
        logic [4:0]  fcnt;
        int          lat;
        int          nld;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] tb_buf [NP];
    logic [15:0] res_tab [NP];
    int          k;
    bit          never;
    bit          stale;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    // array model state
    bit          active;
    int          cnt;
    int          pidx;
    logic [15:0] res_q;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_stw_bist_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .pat_wr_en        (pat_wr_en),
        .pat_wr_addr      (pat_wr_addr),
        .pat_wr_data      (pat_wr_data),
        .num_pat          (num_pat),
        .bist_start       (bist_start),
        .bist_busy        (bist_busy),
        .bist_done        (bist_done),
        .bist_pass        (bist_pass),
        .timeout_err      (timeout_err),
        .fault_map        (fault_map),
        .fault_count      (fault_count),
        .STW_mult_op1     (op1),
        .STW_mult_op2     (op2),
        .STW_add_op       (addop),
        .STW_expected     (expv),
        .STW_test_load_en (load_en),
        .STW_start        (stw_start),
        .STW_complete_in  (complete),
        .STW_result_in    (result)
    );

    // Array completes k cycles after the first WAIT cycle; optional stale
    // complete on the first WAIT cycle; result held from completion.
    assign complete = active && !never && (cnt == k || (stale && cnt == 0));
    assign result   = res_q;

    always @(posedge clk) begin
        if (!rst || !bist_busy) begin
            active <= 1'b0;
            cnt    <= 0;
            pidx   <= 0;
            res_q  <= '0;
        end else if (stw_start) begin
            active <= 1'b1;
            cnt    <= 0;
            res_q  <= '0;
        end else if (active) begin
            cnt <= cnt + 1;
            if (!never && cnt == k) begin
                active <= 1'b0;
                res_q  <= res_tab[pidx];
                pidx   <= pidx + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic session(input int np, input int rst_at, input int inj_at);
        exp_t e;
        int   npe, t0, nld, nst;
        bit   got;
        npe    = (np > NP) ? NP : np;
        e.fmap = '0;
        e.terr = 1'b0;
        if (never && npe > 0) begin
            e.terr = 1'b1;
            e.lat  = 3 + TMO;
            e.nld  = 1;
        end else begin
            for (int i = 0; i < npe; i++) e.fmap |= res_tab[i];
            e.lat = npe * (4 + k) + 1;
            e.nld = npe;
        end
        e.fcnt = 5'($countones(e.fmap));
        e.pass = !e.terr && (e.fmap == 0);
        if (rst_at < 0) exp_q.push_back(e);
        bist_start = 1'b1;
        num_pat    = 4'(np);
        t0         = cyc;
        @(posedge clk); #1;
        bist_start = 1'b0;
        nld = 0;
        nst = 0;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (load_en) nld++;
            if (stw_start) nst++;
            if (bist_busy && !bist_done && nld > 0)
                check("ops", {op1, op2, addop, expv}, tb_buf[nld-1]);
            if (bist_done) begin
                e = exp_q.pop_front();
                check("latency", 64'(cyc - t0), 64'(e.lat));
                check("pass", bist_pass, e.pass);
                check("timeout_err", timeout_err, e.terr);
                check("fault_map", fault_map, e.fmap);
                check("fault_count", fault_count, e.fcnt);
                check("load_pulses", 64'(nld), 64'(e.nld));
                check("start_pulses", 64'(nst), 64'(e.nld));
                got = 1;
                repeat (2) @(posedge clk);
                #1;
                check("pass_hold", {bist_pass, fault_map}, {e.pass, e.fmap});
            end else if (i == rst_at) begin
                rst = 1'b0;
                @(posedge clk); #1;
                check("rst_outs", {bist_busy, bist_done, bist_pass, timeout_err,
                      fault_map, fault_count, load_en, stw_start}, 0);
                check("rst_ops", {op1, op2, addop, expv}, 0);
                rst = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    @(posedge clk); #1;
                    check("rst_no_done", {bist_busy, bist_done}, 0);
                end
                got = 1;
            end else begin
                if (i == inj_at) begin
                    pat_wr_en   = 1'b1;
                    pat_wr_addr = 3'd1;
                    pat_wr_data = ~tb_buf[1];
                    bist_start  = 1'b1;
                end
                @(posedge clk); #1;
                pat_wr_en  = 1'b0;
                bist_start = 1'b0;
            end
        end
        if (!got) check("done_seen", 0, 1);
    endtask

    initial begin
        rst         = 1'b0;
        pat_wr_en   = 1'b0;
        pat_wr_addr = '0;
        pat_wr_data = '0;
        num_pat     = '0;
        bist_start  = 1'b0;
        k           = 2;
        never       = 0;
        stale       = 1;
        for (int i = 0; i < NP; i++) res_tab[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {bist_busy, bist_done, bist_pass, timeout_err,
              fault_map, fault_count, load_en, stw_start}, 0);
        check("reset_ops", {op1, op2, addop, expv}, 0);
        rst = 1'b1;
        for (int i = 0; i < NP; i++) begin
            tb_buf[i]   = {32'($urandom), 32'($urandom)};
            pat_wr_en   = 1'b1;
            pat_wr_addr = 3'(i);
            pat_wr_data = tb_buf[i];
            @(posedge clk); #1;
        end
        pat_wr_en = 1'b0;

        // two clean patterns, complete on WAIT cycle 2, stale complete masked
        session(2, -1, -1);

        // faults on PE 5 then PEs 1 and 5, complete on first legal cycle
        k          = 1;
        res_tab[0] = 16'h0020;
        res_tab[1] = 16'h0000;
        res_tab[2] = 16'h0022;
        session(3, -1, -1);

        // array never completes: abort on first pattern
        never      = 1;
        res_tab[0] = 16'hffff;
        session(3, -1, -1);
        never = 0;

        // empty session
        session(0, -1, -1);

        // reset during WAIT of pattern 1, then a clean rerun
        k = 2;
        for (int i = 0; i < NP; i++) res_tab[i] = '0;
        session(2, 9, -1);
        session(2, -1, -1);

        // write and start while busy are ignored
        k          = 3;
        res_tab[1] = 16'h8001;
        session(2, -1, 4);

        // oversize num_pat clamps to the buffer depth
        k = 1;
        for (int i = 0; i < NP; i++) res_tab[i] = 16'(1 << $urandom_range(0, 15));
        session(15, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
